spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave, the receiving end of the existing SPI master (same `spcon` CPOL/CPHA encoding, MSB first, 8-bit frames).
- Oversamples `sck`, `ssn` and `mosi` in the system clock domain. Shifts one byte out on `miso` while one byte is shifted in from `mosi`.
- Presents the received byte with a one-cycle completion strobe.
- Sits beside the SPI master in the SPI_MS subsystem, typically looped back to it for self-test.

Parameters:
- NUM_SYNC, 2, synchronizer depth for `sck`/`ssn`/`mosi` (legal 2..4).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- spcon  input  8  [0] enable, [1] CPHA, [2] CPOL; other bits ignored
- data_s  input  8  byte to transmit; sampled at each frame/byte start
- sck  input  1  SPI clock from master (asynchronous)
- ssn  input  1  slave select, active-low (asynchronous)
- mosi  input  1  serial data in
- miso  output  1  serial data out
- data_r_s  output  8  last completed received byte
- data_finish_s  output  1  one-cycle pulse: `data_r_s` updated
- busy_s  output  1  high while a byte is in progress

Behaviour:
- Reset (rst_n low at a clk edge):
  - `miso`=0, `data_r_s`=0, `data_finish_s`=0, `busy_s`=0.
  - Shift registers and bit counter cleared; state IDLE.
  - Synchronizer flops are loaded with `sck`=CPOL, `ssn`=1, `mosi`=0.
- Synchronization and edge detection:
  - `sck`, `ssn` and `mosi` each pass through NUM_SYNC flops.
  - Edges are detected on the synced signals against one extra delayed copy.
  - Leading edge = synced `sck` leaves CPOL; trailing edge = synced `sck` returns to CPOL.
- Latency: a pin edge acts NUM_SYNC+1 clk cycles later.
- Legality constraint: each sck half-period must be at least NUM_SYNC+2 clk cycles. Faster `sck` is illegal and behaviour is undefined.
- State IDLE:
  - Entered from any state when synced `ssn`=1 or `spcon[0]`=0.
  - `miso` held 0, `busy_s`=0.
- IDLE -> ACTIVE on the synced `ssn` falling edge with `spcon[0]`=1:
  - Load tx shift register from `data_s`; bit counter = 0; `busy_s`=1.
  - CPHA=0: `miso` drives `data_s[7]` in the same cycle.
- ACTIVE, CPHA=0:
  - Leading edge: sample synced `mosi` into rx shift (shift left, LSB in); counter +1.
  - Trailing edge: shift tx; `miso` = next bit.
- ACTIVE, CPHA=1:
  - Leading edge: `miso` = next tx bit (`data_s[7]` on the first leading edge).
  - Trailing edge: sample `mosi`; counter +1.
- Byte completion, i.e. the 8th sample:
  - Next cycle: `data_r_s` <= full rx byte and `data_finish_s`=1 for exactly one cycle.
  - Counter wraps to 0 and the tx shift register reloads from `data_s`, giving back-to-back bytes while `ssn` stays low.
  - CPHA=0: `miso` drives the new bit 7 at the trailing edge after the 8th sample.
- `ssn` rising mid-byte (counter 1..7):
  - Abort: partial byte discarded, no `data_finish_s`, `data_r_s` unchanged.
  - Return to IDLE.
- `ssn` rising in the same cycle as the 8th-sample completion: the byte completes (pulse issued), then IDLE.
- `spcon` change while ACTIVE is illegal. `spcon[0]` dropping forces IDLE, same as an abort.
- `sck` edges while IDLE are ignored.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- When defined, adds two ports:
  - input `rx_ack_s` (1): host has read `data_r_s`.
  - output `overrun_s` (1): sticky overrun flag.
- An internal pending flag sets on `data_finish_s` and clears on `rx_ack_s`. If both occur in the same cycle, pending stays set.
- `overrun_s` sets when a byte completes while pending=1. It clears only on reset or on `rx_ack_s` with no simultaneous completion.
- `data_r_s` is still overwritten on overrun.
- When the macro is undefined, neither port exists and there is no overrun logic.

Decomposition:
- Package `spi_pkg`:
  - `spcon` bit index constants (SPCON_EN=0, SPCON_CPHA=1, SPCON_CPOL=2).
  - Frame width constant SPI_BITS=8.
  - State enum IDLE/ACTIVE.
- Sub-module `spi_sync_edge`:
  - NUM_SYNC-deep synchronizer plus rise/fall detect.
  - Instantiated for `sck` and `ssn`; plain synchronizer for `mosi`.

Test Plan:
- Mode 0 (spcon=8'h01), NUM_SYNC=2, sck half-period 8 clk. Master sends 8'hA5 with `data_s`=8'h3C. Required: `data_r_s`=8'hA5, one `data_finish_s` pulse, and the master receives 8'h3C.
- Mode 3 (spcon=8'h07), two back-to-back bytes 8'h81 then 8'h7E with `ssn` held low. Required: two pulses, `data_r_s` sequence 81 then 7E, and `miso` reloads `data_s` at the byte boundary.
- Modes 1 and 2 (spcon 8'h03, 8'h05), byte 8'hF0 in each. Required: correct capture, and `miso` changes only on the CPHA-defined edge.
- Abort: `ssn` raised after 5 `sck` cycles. Required: no pulse, `data_r_s` unchanged, `busy_s`=0 within NUM_SYNC+2 cycles; the next full byte 8'h55 is received correctly.
- Reset mid-byte: assert rst_n low for 1 clk at bit 4. Required: all outputs 0 on the next clk edge and IDLE; a subsequent frame 8'hC3 is received correctly.
- With SPI_SLAVE_OVERRUN_EN: two bytes without `rx_ack_s`. Required: `overrun_s`=1 after the second pulse and `data_r_s` equals the second byte; `rx_ack_s` clears it.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI control-register bit positions, frame width and slave states
package spi_pkg;
    localparam int SPCON_EN   = 0;
    localparam int SPCON_CPHA = 1;
    localparam int SPCON_CPOL = 2;
    localparam int SPI_BITS   = 8;
    typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: NUM_SYNC-deep synchronizer with rise/fall detect against one delayed copy
module spi_sync_edge #(
    parameter int NUM_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    input  logic rst_val_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [NUM_SYNC-1:0] sync_q;
    logic                dly_q;
    // Synchronizer chain plus one extra stage for edge comparison; reset preloads the idle level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {NUM_SYNC{rst_val_i}};
            dly_q  <= rst_val_i;
        end else begin
            sync_q <= {sync_q[NUM_SYNC-2:0], d_i};
            dly_q  <= sync_q[NUM_SYNC-1];
        end
    end
    assign q_o    = sync_q[NUM_SYNC-1];
    assign rise_o = q_o & ~dly_q;
    assign fall_o = ~q_o & dly_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, MSB first, 8-bit frames; SPI_SLAVE_OVERRUN_EN adds rx_ack_s/overrun_s
module spi_slave
    import spi_pkg::*;
#(
    parameter int NUM_SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] spcon,
    input  logic [7:0] data_s,
    input  logic       sck,
    input  logic       ssn,
    input  logic       mosi,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic       rx_ack_s,
    output logic       overrun_s,
`endif
    output logic       miso,
    output logic [7:0] data_r_s,
    output logic       data_finish_s,
    output logic       busy_s
);
    localparam int CW = $clog2(SPI_BITS);
    logic                cpol, cpha, en;
    logic                sck_unused, ssn_rise_unused, unused_spcon;
    logic                sck_rise, sck_fall, ssn_s, ssn_fall, mosi_s;
    logic                lead, trail, sample, tx_edge, tx_hold, last;
    logic [NUM_SYNC-1:0] mosi_q;
    state_e              state_q;
    logic [SPI_BITS-1:0] tx_q, rx_q, rx_next, data_r_q;
    logic [CW-1:0]       cnt_q;
    logic                miso_q, fin_q, busy_q;

    assign cpol         = spcon[SPCON_CPOL];
    assign cpha         = spcon[SPCON_CPHA];
    assign en           = spcon[SPCON_EN];
    assign unused_spcon = ^spcon[7:3];

    spi_sync_edge #(.NUM_SYNC(NUM_SYNC)) u_sck (
        .clk(clk), .rst_n(rst_n), .d_i(sck), .rst_val_i(cpol),
        .q_o(sck_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.NUM_SYNC(NUM_SYNC)) u_ssn (
        .clk(clk), .rst_n(rst_n), .d_i(ssn), .rst_val_i(1'b1),
        .q_o(ssn_s), .rise_o(ssn_rise_unused), .fall_o(ssn_fall)
    );

    // mosi only needs the same delay as sck so data and clock stay aligned
    always_ff @(posedge clk) begin
        if (!rst_n) mosi_q <= '0;
        else        mosi_q <= {mosi_q[NUM_SYNC-2:0], mosi};
    end
    assign mosi_s = mosi_q[NUM_SYNC-1];

    assign lead    = cpol ? sck_fall : sck_rise;
    assign trail   = cpol ? sck_rise : sck_fall;
    assign sample  = cpha ? trail : lead;
    assign tx_edge = cpha ? lead : trail;
    assign tx_hold = !cpha && cnt_q == '0;
    assign last    = cnt_q == CW'(SPI_BITS - 1);
    assign rx_next = {rx_q[SPI_BITS-2:0], mosi_s};

    // Frame FSM: sample/shift on the CPHA-selected edges, complete on the 8th sample, drop out when deselected
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
            miso_q   <= 1'b0;
            data_r_q <= '0;
            fin_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (state_q == IDLE) begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
                if (ssn_fall && en) begin
                    state_q <= ACTIVE;
                    busy_q  <= 1'b1;
                    tx_q    <= data_s;
                    cnt_q   <= '0;
                    miso_q  <= cpha ? 1'b0 : data_s[7];
                end
            end else begin
                if (sample) begin
                    rx_q  <= rx_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        data_r_q <= rx_next;
                        fin_q    <= 1'b1;
                        tx_q     <= data_s;
                    end
                end else if (tx_edge) begin
                    miso_q <= (tx_hold || cpha) ? tx_q[SPI_BITS-1] : tx_q[SPI_BITS-2];
                    tx_q   <= tx_hold ? tx_q : tx_q << 1;
                end
                if (ssn_s || !en) begin
                    state_q <= IDLE;
                    miso_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            end
        end
    end

    assign miso          = miso_q;
    assign data_r_s      = data_r_q;
    assign data_finish_s = fin_q;
    assign busy_s        = busy_q;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic pend_q, ovr_q;
    // Pending marks an unread byte; a completion on top of it raises a sticky overrun until acknowledged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= fin_q ? 1'b1 : (rx_ack_s ? 1'b0 : pend_q);
            ovr_q  <= fin_q ? (ovr_q | pend_q) : (rx_ack_s ? 1'b0 : ovr_q);
        end
    end
    assign overrun_s = ovr_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI-master stimulus against spi_slave with hand-computed expectations
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] spcon = 8'h01;
    logic [7:0] data_s = 8'h00;
    logic       sck = 1'b0;
    logic       ssn = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] data_r_s;
    logic       data_finish_s;
    logic       busy_s;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack_s = 1'b0;
    logic       overrun_s;
`endif

    spi_slave #(.NUM_SYNC(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spcon(spcon),
        .data_s(data_s),
        .sck(sck),
        .ssn(ssn),
        .mosi(mosi),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ack_s(rx_ack_s),
        .overrun_s(overrun_s),
`endif
        .miso(miso),
        .data_r_s(data_r_s),
        .data_finish_s(data_finish_s),
        .busy_s(busy_s)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         fin_cnt = 0;
    int         edge_bad = 0;
    int         last_edge = 2;
    logic       prev_miso = 1'b0;
    logic [7:0] fin_data[$];

    // Monitor: count completion pulses, log their bytes, and flag miso moving on the wrong sck edge
    always @(negedge clk) begin
        if (data_finish_s) begin
            fin_cnt <= fin_cnt + 1;
            fin_data.push_back(data_r_s);
        end
        if (busy_s && miso !== prev_miso && !(spcon[1] ? last_edge == 0 : last_edge != 0))
            edge_bad <= edge_bad + 1;
        prev_miso <= miso;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ssn_low();
        ssn = 1'b0;
        last_edge = 2;
        cyc(8);
    endtask

    task automatic ssn_high();
        ssn = 1'b1;
        cyc(16);
    endtask

    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        if (!spcon[1]) begin
            mosi = tx[7];
            cyc(8);
        end
        for (int i = 7; i > 7 - n; i--) begin
            sck = ~spcon[2];
            last_edge = 0;
            if (spcon[1]) mosi = tx[i];
            else rx[i] = miso;
            cyc(8);
            sck = spcon[2];
            last_edge = 1;
            if (spcon[1]) rx[i] = miso;
            else if (i > 0) mosi = tx[i-1];
            cyc(8);
        end
    endtask

    initial begin
        logic [7:0] rx, rx2;
        int f;
        cyc(3);
        chk("rst_miso", miso, 0);
        chk("rst_data_r", data_r_s, 0);
        chk("rst_finish", data_finish_s, 0);
        chk("rst_busy", busy_s, 0);
        rst_n = 1'b1;
        cyc(8);

        data_s = 8'h3C;
        f = fin_cnt;
        ssn_low();
        chk("m0_busy", busy_s, 1);
        xfer(8'hA5, 8, rx);
        ssn_high();
        chk("m0_data_r", data_r_s, 8'hA5);
        chk("m0_pulses", fin_cnt - f, 1);
        chk("m0_master_rx", rx, 8'h3C);
        chk("m0_edges", edge_bad, 0);

        spcon = 8'h07;
        sck = 1'b1;
        data_s = 8'h5A;
        cyc(16);
        f = fin_cnt;
        ssn_low();
        data_s = 8'hC3;
        xfer(8'h81, 8, rx);
        xfer(8'h7E, 8, rx2);
        ssn_high();
        chk("m3_pulses", fin_cnt - f, 2);
        chk("m3_first", fin_data[fin_data.size()-2], 8'h81);
        chk("m3_second", fin_data[fin_data.size()-1], 8'h7E);
        chk("m3_master_rx1", rx, 8'h5A);
        chk("m3_master_rx2", rx2, 8'hC3);
        chk("m3_edges", edge_bad, 0);

        spcon = 8'h03;
        sck = 1'b0;
        data_s = 8'h96;
        cyc(16);
        f = fin_cnt;
        ssn_low();
        xfer(8'hF0, 8, rx);
        ssn_high();
        chk("m1_data_r", data_r_s, 8'hF0);
        chk("m1_pulses", fin_cnt - f, 1);
        chk("m1_master_rx", rx, 8'h96);
        chk("m1_edges", edge_bad, 0);

        spcon = 8'h05;
        sck = 1'b1;
        data_s = 8'h69;
        cyc(16);
        f = fin_cnt;
        ssn_low();
        xfer(8'hF0, 8, rx);
        ssn_high();
        chk("m2_data_r", data_r_s, 8'hF0);
        chk("m2_pulses", fin_cnt - f, 1);
        chk("m2_master_rx", rx, 8'h69);
        chk("m2_edges", edge_bad, 0);

        spcon = 8'h01;
        sck = 1'b0;
        data_s = 8'hAA;
        cyc(16);
        f = fin_cnt;
        ssn_low();
        chk("ab_miso_first", miso, 1);
        xfer(8'hFF, 5, rx);
        ssn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("ab_busy", busy_s, 0);
        cyc(16);
        chk("ab_pulses", fin_cnt - f, 0);
        chk("ab_data_r", data_r_s, 8'hF0);
        ssn_low();
        xfer(8'h55, 8, rx);
        ssn_high();
        chk("ab_next_data_r", data_r_s, 8'h55);
        chk("ab_next_pulses", fin_cnt - f, 1);
        chk("ab_next_rx", rx, 8'hAA);

        data_s = 8'hE7;
        ssn_low();
        xfer(8'hC3, 4, rx);
        rst_n = 1'b0;
        ssn = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_miso", miso, 0);
        chk("mr_data_r", data_r_s, 0);
        chk("mr_finish", data_finish_s, 0);
        chk("mr_busy", busy_s, 0);
        rst_n = 1'b1;
        cyc(16);
        f = fin_cnt;
        ssn_low();
        xfer(8'hC3, 8, rx);
        ssn_high();
        chk("mr_next_data_r", data_r_s, 8'hC3);
        chk("mr_next_pulses", fin_cnt - f, 1);
        chk("mr_next_rx", rx, 8'hE7);

`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack_s = 1'b1;
        cyc(1);
        rx_ack_s = 1'b0;
        cyc(2);
        chk("ov_clear_start", overrun_s, 0);
        ssn_low();
        xfer(8'h12, 8, rx);
        chk("ov_after_first", overrun_s, 0);
        xfer(8'h34, 8, rx);
        ssn_high();
        chk("ov_set", overrun_s, 1);
        chk("ov_data_r", data_r_s, 8'h34);
        rx_ack_s = 1'b1;
        cyc(1);
        rx_ack_s = 1'b0;
        cyc(2);
        chk("ov_ack_clear", overrun_s, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
